// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage of a pipelined core.
// A request accepted in IDLE is captured, held for WAIT_CYCLES wait states,
// then performed on the completing edge with a one-cycle Ready pulse.
// Stall is combinational so the pipeline freezes in the same cycle the
// request is presented.
//
// Optional feature: define DMEM_ERROR_CHECK_EN to reject misaligned,
// out-of-range and read+write requests with a one-cycle Error pulse.
// Without it, Address[1:0] is ignored, the word index wraps modulo
// DEPTH_WORDS, a write wins over a simultaneous read, and Error stays 0.
module data_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,   // legal range 0..15
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Ready,
  output logic        Error
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            is_write_q, is_write_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;

  // Not reset: contents survive rst.
  logic [31:0]     mem [DEPTH_WORDS];

  logic [29:0]     word_idx;
  logic [IdxW-1:0] req_idx;
  logic            req_valid;
  logic            req_legal;
  logic            req_is_write;
  logic            do_write;

  assign word_idx  = Address[31:2];
  assign req_valid = (state_q == StIdle) && (MemRead || MemWrite);

`ifdef DMEM_ERROR_CHECK_EN
  assign req_legal    = (Address[1:0] == 2'b00) &&
                        ({2'b00, word_idx} < DEPTH_WORDS) &&
                        !(MemRead && MemWrite);
  assign req_is_write = MemWrite;
  assign req_idx      = word_idx[IdxW-1:0];
`else
  logic [31:0] wrap_idx;
  logic        unused_bits;

  assign wrap_idx     = {2'b00, word_idx} % DEPTH_WORDS;
  assign req_legal    = 1'b1;
  // Write wins when both request lines are high.
  assign req_is_write = MemWrite;
  assign req_idx      = wrap_idx[IdxW-1:0];
  assign unused_bits  = ^{Address[1:0], wrap_idx[31:IdxW]};
`endif

  // The access is performed on the edge that leaves WAIT with the counter at zero.
  assign do_write = (state_q == StWait) && (cnt_q == 4'd0) && is_write_q;

  // Next-state, capture and output decode; defaults hold all state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    read_data_d = read_data_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    Stall       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_legal) begin
            idx_d      = req_idx;
            wdata_d    = WriteData;
            is_write_d = req_is_write;
            cnt_d      = 4'(WAIT_CYCLES);
            state_d    = StWait;
            Stall      = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StWait: begin
        Stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          state_d = StDone;
          if (!is_write_q) begin
            read_data_d = mem[idx_q];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and datapath registers; reset wins over any completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      is_write_q  <= 1'b0;
      read_data_q <= 32'd0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  // Memory write port; a reset in WAIT aborts the pending store.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ReadData = read_data_q;
  assign Ready    = ready_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Two instances: WAIT_CYCLES=2
// (sel 0) and WAIT_CYCLES=0 (sel 1). Expected completions are queued when a
// request is driven and popped at the Ready pulse. DMEM_ERROR_CHECK_EN selects
// which illegal/aliasing cases are exercised.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] a2, d2, a0, d0;
  logic [31:0] q2, q0;
  logic        s2, s0, r2, r0, e2, e0;

  data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) dut (
    .clk(clk), .rst(rst), .MemRead(rd2), .MemWrite(wr2), .Address(a2), .WriteData(d2),
    .ReadData(q2), .Stall(s2), .Ready(r2), .Error(e2)
  );

  data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) dut0 (
    .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .Address(a0), .WriteData(d0),
    .ReadData(q0), .Stall(s0), .Ready(r0), .Error(e0)
  );

  int          sel;
  logic [31:0] o_q;
  logic        o_s, o_r, o_e;
  assign o_q = (sel == 1) ? q0 : q2;
  assign o_s = (sel == 1) ? s0 : s2;
  assign o_r = (sel == 1) ? r0 : r2;
  assign o_e = (sel == 1) ? e0 : e2;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];
  logic [31:0] last_rd [2];
  int          checks = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (s == 1) begin
      rd0 = rd; wr0 = wr; a0 = a; d0 = d;
    end else begin
      rd2 = rd; wr2 = wr; a2 = a; d2 = d;
    end
  endtask

  // One legal access on the selected instance, checked cycle by cycle.
  task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit toggle, input string tag);
    exp_t e;
    int   lat = -1;
    int   stalls = 0;
    bit   err_seen = 0;
    int   w = (sel == 1) ? 0 : 2;
    int   idx = int'((addr >> 2) % 256);
    if (wr) begin
      model[sel][idx] = data;
      e.is_read = 0;
      e.data    = last_rd[sel];
    end else begin
      e.is_read    = 1;
      e.data       = model[sel][idx];
      last_rd[sel] = e.data;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    drive(sel, rd, wr, addr, data);
    @(negedge clk);
    if (o_s) stalls++;
    if (o_e) err_seen = 1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (toggle) drive(sel, 1'b0, c[0], addr ^ 32'h4, $urandom);
      else drive(sel, 1'b0, 1'b0, addr, data);
      @(negedge clk);
      if (o_s) stalls++;
      if (o_e) err_seen = 1;
      if (o_r) lat = c;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(w + 2));
    check_eq({tag, "_stalls"}, 32'(stalls), 32'(w + 2));
    check_eq({tag, "_error"}, 32'(err_seen), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, "_rdata"}, o_q, e.data);
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_eq({tag, "_idle"}, {30'd0, o_r, o_s}, 32'd0);
  endtask

`ifdef DMEM_ERROR_CHECK_EN
  // Illegal request: one-cycle Error, no stall, no Ready, ReadData held.
  task automatic run_bad(input bit rd, input bit wr, input logic [31:0] addr, input string tag);
    @(posedge clk); #1;
    drive(sel, rd, wr, addr, 32'h0BAD0BAD);
    @(negedge clk);
    check_eq({tag, "_stall"}, {31'd0, o_s}, 32'd0);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_eq({tag, "_err"}, {30'd0, o_e, o_r}, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({tag, "_err_clr"}, {30'd0, o_e, o_r}, 32'd0);
    check_eq({tag, "_rdata"}, o_q, last_rd[sel]);
  endtask
`endif

  initial begin
    bit          rdy_seen;
    logic [31:0] rnd_addr [4];

    rst = 1'b1;
    sel = 0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_w2", {q2[31:3], q2[2:0] | {r2, e2, s2}}, 32'd0);
    check_eq("reset_w0", {q0[31:3], q0[2:0] | {r0, e0, s0}}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back with two wait states.
    run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr_10");
    run_req(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, "rd_10");

    // Inputs wiggling during WAIT must not disturb the captured write.
    run_req(1'b0, 1'b1, 32'h34, 32'h00000055, 1'b0, "wr_34");
    run_req(1'b0, 1'b1, 32'h30, 32'h11112222, 1'b1, "wr_30_toggle");
    run_req(1'b1, 1'b0, 32'h30, 32'd0, 1'b0, "rd_30");
    run_req(1'b1, 1'b0, 32'h34, 32'd0, 1'b0, "rd_34");

    // Random words in a scratch region.
    for (int i = 0; i < 4; i++) begin
      rnd_addr[i] = 32'($urandom_range(64, 127)) << 2;
      run_req(1'b0, 1'b1, rnd_addr[i], $urandom, 1'b0, "wr_rnd");
    end
    for (int i = 0; i < 4; i++) begin
      run_req(1'b1, 1'b0, rnd_addr[i], 32'd0, 1'b0, "rd_rnd");
    end

`ifdef DMEM_ERROR_CHECK_EN
    run_bad(1'b1, 1'b0, 32'h13, "bad_misalign");
    run_bad(1'b1, 1'b0, 32'h400, "bad_range");
    run_bad(1'b1, 1'b1, 32'h10, "bad_both");
`else
    // Both lines high: write wins, 0x403 aliases to word 0.
    run_req(1'b1, 1'b1, 32'h403, 32'hA5A5A5A5, 1'b0, "wr_alias");
    run_req(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, "rd_alias");
`endif

    // Reset during WAIT aborts the pending write.
    run_req(1'b0, 1'b1, 32'h20, 32'h0, 1'b0, "wr_20_zero");
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    check_eq("rst_req_stall", {31'd0, s2}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (r2) rdy_seen = 1;
    end
    check_eq("rst_no_ready", {31'd0, rdy_seen}, 32'd0);
    check_eq("rst_state", {30'd0, s2, r2}, 32'd0);
    check_eq("rst_rdata", q2, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    run_req(1'b1, 1'b0, 32'h20, 32'd0, 1'b0, "rd_20_after_rst");

    // Zero wait states.
    sel = 1;
    run_req(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0, "w0_wr_40");
    run_req(1'b1, 1'b0, 32'h40, 32'd0, 1'b0, "w0_rd_40");

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
